// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: RV32M op codes, sequencer states and operand-sign helpers
package muldiv_sequencer_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_e;
  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction
  function automatic logic a_signed(input op_e op);
    return op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM;
  endfunction
  function automatic logic b_signed(input op_e op);
    return op == OP_MULH || op == OP_DIV || op == OP_REM;
  endfunction
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/response bundle between EX stage and the mul/div unit
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  modport master (output start, op, rs1, rs2, flush, input busy, done, result);
  modport slave (input start, op, rs1, rs2, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_addsub.sv
// muldiv_addsub: shared add/subtract, subtraction as a + ~b + 1
module muldiv_addsub #(parameter int N = 33) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] y_o
);
  assign y_o = a_i + (b_i ^ {N{sub_i}}) + N'(sub_i);
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply (shift-add) and divide (restoring) unit
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic reset,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [W2-1:0] acc_q, acc_d, prod_fix;
  logic [WIDTH-1:0] b_q, b_d, result_q, result_d, lo, hi, abs_a, abs_b, result_fix;
  logic [CW-1:0] cnt_q, cnt_d;
  logic negq_q, negq_d, negr_q, negr_d, busy_q, busy_d, done_q, done_d;
  logic sa, sb, b_zero, ovf, special;
  logic [WIDTH:0] shifted, as_a, as_b, as_y;
  assign lo = acc_q[WIDTH-1:0];
  assign hi = acc_q[W2-1:WIDTH];
  assign sa = a_signed(op_q) && lo[WIDTH-1];
  assign sb = b_signed(op_q) && b_q[WIDTH-1];
  assign abs_a = sa ? -lo : lo;
  assign abs_b = sb ? -b_q : b_q;
  assign b_zero = b_q == '0;
  assign ovf = (op_q == OP_DIV || op_q == OP_REM) && lo == {1'b1, {(WIDTH-1){1'b0}}} && &b_q;
  assign special = BYPASS != 0 && is_div(op_q) && (b_zero || ovf);
  assign shifted = {hi, lo[WIDTH-1]};
  assign as_a = is_div(op_q) ? shifted : {1'b0, hi};
  assign as_b = is_div(op_q) || lo[0] ? {1'b0, b_q} : '0;
  muldiv_addsub #(.N(WIDTH + 1)) u_addsub (.a_i(as_a), .b_i(as_b), .sub_i(is_div(op_q)), .y_o(as_y));
  assign prod_fix = negq_q ? -acc_q : acc_q;
  assign result_fix = !is_div(op_q) ? (op_q == OP_MUL ? prod_fix[WIDTH-1:0] : prod_fix[W2-1:WIDTH])
                    : op_q[1] ? (negr_q ? -hi : hi) : (negq_q ? -lo : lo);
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.result = result_q;
  // next-state: latch, take magnitudes, iterate on the shared adder, then sign-fix and publish
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    acc_d = acc_q;
    b_d = b_q;
    cnt_d = cnt_q;
    negq_d = negq_q;
    negr_d = negr_q;
    result_d = result_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_PREP;
        op_d = op_e'(bus.op);
        acc_d = {{WIDTH{1'b0}}, bus.rs1};
        b_d = bus.rs2;
      end
      S_PREP: begin
        state_d = special ? S_FIX : S_ITER;
        cnt_d = '0;
        negq_d = (sa ^ sb) && !(is_div(op_q) && b_zero);
        negr_d = sa;
        acc_d = !is_div(op_q) ? {{WIDTH{1'b0}}, abs_b}
              : (special && b_zero) ? {abs_a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, abs_a};
        b_d = is_div(op_q) ? abs_b : abs_a;
      end
      S_ITER: begin
        acc_d = is_div(op_q) ? {as_y[WIDTH] ? shifted[WIDTH-1:0] : as_y[WIDTH-1:0], lo[WIDTH-2:0], ~as_y[WIDTH]}
              : {as_y, lo[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(WIDTH - 1) ? S_FIX : S_ITER;
      end
      S_FIX: begin
        result_d = result_fix;
        done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) begin
      state_d = S_IDLE;
      done_d = 1'b0;
      result_d = result_q;
    end
    busy_d = state_d == S_PREP || state_d == S_ITER;
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q <= OP_MUL;
      acc_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      result_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      acc_q <= acc_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      result_q <= result_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed checks of results, latency, busy/done timing, flush and reset
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int n, bn, nd;
  muldiv_sequencer_if #(.WIDTH(32)) bus ();
  muldiv_sequencer #(.WIDTH(32), .BYPASS(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op = o;
    bus.rs1 = a;
    bus.rs2 = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) busy_cyc++;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      if (bus.done === 1'b1) cnt++;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] exp);
    int c, bc;
    launch(o, a, b);
    wait_done(c, bc);
    check({tag, " latency"}, c, lat);
    check({tag, " result"}, bus.result, exp);
    check({tag, " busy cycles"}, bc, lat - 1);
    check({tag, " busy at done"}, {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, " result hold"}, bus.result, exp);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op = 3'b000;
    bus.rs1 = '0;
    bus.rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset result", bus.result, 32'd0);
    run_op("MUL 7x-3", 3'b000, 32'd7, 32'hFFFFFFFD, 34, 32'hFFFFFFEB);
    run_op("MULHU", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE);
    run_op("MULH", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'h00000000);
    run_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFF);
    run_op("DIV -20/6", 3'b100, 32'hFFFFFFEC, 32'd6, 34, 32'hFFFFFFFD);
    run_op("REM -20/6", 3'b110, 32'hFFFFFFEC, 32'd6, 34, 32'hFFFFFFFE);
    run_op("DIVU 20/6", 3'b101, 32'd20, 32'd6, 34, 32'd3);
    run_op("REMU 20/6", 3'b111, 32'd20, 32'd6, 34, 32'd2);
    run_op("DIV x/0", 3'b100, 32'h12345678, 32'd0, 2, 32'hFFFFFFFF);
    run_op("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 2, 32'h00000000);
    run_op("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 2, 32'h80000000);
    run_op("REM -7/0", 3'b110, 32'hFFFFFFF9, 32'd0, 2, 32'hFFFFFFF9);
    run_op("DIVU big", 3'b101, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000);
    launch(3'b000, 32'd3, 32'd4);
    repeat (5) @(posedge clk);
    #1;
    bus.op = 3'b101;
    bus.rs1 = 32'd100;
    bus.rs2 = 32'd0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(n, bn);
    check("start while busy latency", n + 6, 34);
    check("start while busy result", bus.result, 32'd12);
    @(posedge clk);
    #1;
    launch(3'b000, 32'd5, 32'd5);
    repeat (11) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush busy", {31'd0, bus.busy}, 32'd0);
    count_done(40, nd);
    check("flush no done", nd, 0);
    check("flush result", bus.result, 32'd12);
    bus.op = 3'b000;
    bus.rs1 = 32'd2;
    bus.rs2 = 32'd2;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush+start busy", {31'd0, bus.busy}, 32'd0);
    count_done(40, nd);
    check("flush+start no done", nd, 0);
    run_op("DIVU after flush", 3'b101, 32'd100, 32'd7, 34, 32'd14);
    launch(3'b000, 32'd7, 32'hFFFFFFFD);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid reset busy", {31'd0, bus.busy}, 32'd0);
    check("mid reset done", {31'd0, bus.done}, 32'd0);
    check("mid reset result", bus.result, 32'd0);
    count_done(40, nd);
    check("mid reset no done", nd, 0);
    run_op("DIV 100/-7", 3'b100, 32'd100, 32'hFFFFFFF9, 34, 32'hFFFFFFF2);
    run_op("REM 100/-7", 3'b110, 32'd100, 32'hFFFFFFF9, 34, 32'd2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
